// File: rtl/sensing_scheduler_pkg.sv
// Shared types and constants for the sensing scheduler and the drive FSMs.
// State encodings double as the LED/debug code on state_out.
package sensing_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_LISTEN   = 3'd0;
  localparam state_t ST_SETTLE   = 3'd1;
  localparam state_t ST_WAIT_SOP = 3'd2;
  localparam state_t ST_IN_FRAME = 3'd3;
  localparam state_t ST_SEND     = 3'd4;
  localparam state_t ST_COOLDOWN = 3'd5;

  localparam logic [3:0] DIR_IDLE_BASE   = 4'd0;
  localparam logic [3:0] DIR_FORWARD     = 4'd1;
  localparam logic [3:0] DIR_REVERSE     = 4'd2;
  localparam logic [3:0] DIR_TURN_LEFT   = 4'd3;
  localparam logic [3:0] DIR_IDLE_TABLE  = 4'd4;
  localparam logic [3:0] DIR_TURN_RIGHT  = 4'd5;
  localparam logic [3:0] DIR_PIVOT_LEFT  = 4'd6;
  localparam logic [3:0] DIR_PIVOT_RIGHT = 4'd7;
  localparam logic [3:0] DIR_STOP        = 4'd8;

  localparam int DEF_SETTLE_CYCLES   = 50000;
  localparam int DEF_NUM_FRAMES      = 1;
  localparam int DEF_TIMEOUT_CYCLES  = 50_000_000;
  localparam int DEF_COOLDOWN_CYCLES = 25000;
  localparam int DEF_PERIOD_CYCLES   = 500_000_000;

  // Counter width wide enough for the largest of three load values, plus one.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sensing_scheduler_if.sv
// Control/status bundle between the sensing scheduler and the FFT, camera and UART sender.
interface sensing_scheduler_if;

  logic [3:0] direction;
  logic       capture_req;
  logic       frame_sop;
  logic       frame_eop;
  logic       sender_idle;
  logic       fft_enable;
  logic       colour_latch;
  logic       sender_start;
  logic       busy;
  logic [2:0] state_out;
  logic       timeout_err;

  modport master (
    input  direction, capture_req, frame_sop, frame_eop, sender_idle,
    output fft_enable, colour_latch, sender_start, busy, state_out, timeout_err
  );

  modport slave (
    output direction, capture_req, frame_sop, frame_eop, sender_idle,
    input  fft_enable, colour_latch, sender_start, busy, state_out, timeout_err
  );

endinterface

// File: rtl/sensing_scheduler_sched_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module sched_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/sensing_scheduler.sv
// Time-shares mic/FFT and camera/UART: trigger -> FFT off (2 cycles) -> settle -> N frames -> send -> cooldown.
// Optional periodic auto-capture is enabled by defining SENSING_PERIODIC_CAPTURE_EN.
module sensing_scheduler
  import sensing_sched_pkg::*;
#(
  parameter int         SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int         NUM_FRAMES      = DEF_NUM_FRAMES,
  parameter int         TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int         COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
`ifdef SENSING_PERIODIC_CAPTURE_EN
  parameter int         PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
`endif
  parameter logic [3:0] IDLE_TABLE_CODE = DIR_IDLE_TABLE
) (
  input logic               clk,
  input logic               rst_n,
  sensing_scheduler_if.master bus
);

  localparam int TW = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES, COOLDOWN_CYCLES);
  localparam int FW = $clog2(NUM_FRAMES + 1);

  // Timers expire on reaching zero, so loading N-1 makes a state last exactly N cycles.
  localparam logic [TW-1:0] LD_SETTLE   = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] LD_TIMEOUT  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LD_COOLDOWN = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [FW-1:0] LAST_FRAME  = FW'(NUM_FRAMES - 1);

  state_t          state;
  state_t          state_nxt;
  logic            pending;
  logic [3:0]      prev_direction;
  logic [FW-1:0]   frame_cnt;
  logic [FW-1:0]   frame_cnt_nxt;
  logic            ack_seen;
  logic            ack_seen_nxt;
  logic            timeout_err;
  logic            sender_start_q;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_expired;
  logic            err_set;
  logic            latch;
  logic            start;
  logic            auto_trig;
  logic            per_trig;
  logic            trig;

  sched_timer #(.W(TW)) u_state_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (1'b1),
    .expired  (tmr_expired)
  );

`ifdef SENSING_PERIODIC_CAPTURE_EN
  localparam int            PW        = $clog2(PERIOD_CYCLES) + 1;
  localparam logic [PW-1:0] LD_PERIOD = PW'(PERIOD_CYCLES - 1);

  logic per_expired;

  // Free-running; any capture start re-arms the full period.
  sched_timer #(.W(PW), .RST_VAL(LD_PERIOD)) u_period_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start | per_expired),
    .load_val (LD_PERIOD),
    .en       (1'b1),
    .expired  (per_expired)
  );

  assign per_trig = per_expired && (state == ST_LISTEN);
`else
  assign per_trig = 1'b0;
`endif

  assign auto_trig = (bus.direction == IDLE_TABLE_CODE) && (prev_direction != IDLE_TABLE_CODE);
  assign trig      = auto_trig | bus.capture_req | per_trig;

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    ack_seen_nxt  = ack_seen;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    err_set       = 1'b0;
    latch         = 1'b0;
    start         = 1'b0;

    case (state)
      ST_LISTEN: begin
        if (pending) begin
          start     = 1'b1;
          state_nxt = ST_SETTLE;
          tmr_load  = 1'b1;
          tmr_val   = LD_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (tmr_expired) begin
          state_nxt     = ST_WAIT_SOP;
          frame_cnt_nxt = '0;
          tmr_load      = 1'b1;
          tmr_val       = LD_TIMEOUT;
        end
      end

      // An eop here closes a frame we never saw start, so it is ignored.
      ST_WAIT_SOP: begin
        if (bus.frame_sop) begin
          state_nxt = ST_IN_FRAME;
          tmr_load  = 1'b1;
          tmr_val   = LD_TIMEOUT;
        end else if (tmr_expired) begin
          state_nxt = ST_COOLDOWN;
          err_set   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LD_COOLDOWN;
        end
      end

      ST_IN_FRAME: begin
        if (bus.frame_eop) begin
          tmr_load = 1'b1;
          if (frame_cnt == LAST_FRAME) begin
            latch        = 1'b1;
            state_nxt    = ST_SEND;
            ack_seen_nxt = 1'b0;
            tmr_val      = LD_TIMEOUT;
          end else begin
            frame_cnt_nxt = frame_cnt + FW'(1);
            tmr_val       = LD_TIMEOUT;
            state_nxt     = bus.frame_sop ? ST_IN_FRAME : ST_WAIT_SOP;
          end
        end else if (bus.frame_sop) begin
          // Missing eop: treat as a fresh frame start without counting.
          tmr_load = 1'b1;
          tmr_val  = LD_TIMEOUT;
        end else if (tmr_expired) begin
          state_nxt = ST_COOLDOWN;
          err_set   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LD_COOLDOWN;
        end
      end

      ST_SEND: begin
        if (!ack_seen && !bus.sender_idle) begin
          ack_seen_nxt = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = LD_TIMEOUT;
        end else if (ack_seen && bus.sender_idle) begin
          state_nxt = ST_COOLDOWN;
          tmr_load  = 1'b1;
          tmr_val   = LD_COOLDOWN;
        end else if (tmr_expired) begin
          state_nxt = ST_COOLDOWN;
          err_set   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = LD_COOLDOWN;
        end
      end

      ST_COOLDOWN: begin
        if (tmr_expired) begin
          state_nxt = ST_LISTEN;
        end
      end

      default: begin
        state_nxt = ST_LISTEN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_LISTEN;
      pending        <= 1'b0;
      prev_direction <= IDLE_TABLE_CODE;
      frame_cnt      <= '0;
      ack_seen       <= 1'b0;
      timeout_err    <= 1'b0;
      sender_start_q <= 1'b0;
    end else begin
      state          <= state_nxt;
      pending        <= (pending & ~start) | trig;
      prev_direction <= bus.direction;
      frame_cnt      <= frame_cnt_nxt;
      ack_seen       <= ack_seen_nxt;
      timeout_err    <= timeout_err | err_set;
      sender_start_q <= (state_nxt == ST_SEND) && (state != ST_SEND);
    end
  end

  assign bus.fft_enable   = (state == ST_LISTEN) || (state == ST_COOLDOWN);
  assign bus.busy         = (state != ST_LISTEN);
  assign bus.state_out    = state;
  assign bus.colour_latch = latch;
  assign bus.sender_start = sender_start_q;
  assign bus.timeout_err  = timeout_err;

endmodule

// File: tb/tb_sensing_scheduler.sv
// Directed bench: SETTLE=4, NUM_FRAMES=2, TIMEOUT=100, COOLDOWN=3; inputs change 2 time units after posedge.
module tb_sensing_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_latch  = 0;
  int   n_start  = 0;

  sensing_scheduler_if bus();

  sensing_scheduler #(
    .SETTLE_CYCLES   (4),
    .NUM_FRAMES      (2),
    .TIMEOUT_CYCLES  (100),
    .COOLDOWN_CYCLES (3),
    .IDLE_TABLE_CODE (4'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.colour_latch === 1'b1) n_latch++;
      if (bus.sender_start === 1'b1) n_start++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_core(input string tag, input int st, input logic fft, input logic bsy);
    chk({tag, "_state"}, 32'(bus.state_out), 32'(st));
    chk({tag, "_fft"},   32'(bus.fft_enable), 32'(fft));
    chk({tag, "_busy"},  32'(bus.busy), 32'(bsy));
  endtask

  // Entered in WAIT_SOP; sop on cycle 1, eop on cycle len.
  task automatic do_frame(input int len, input logic exp_latch);
    bus.frame_sop = 1'b1;
    cyc(1);
    bus.frame_sop = 1'b0;
    #1;
    chk("frame_in", 32'(bus.state_out), 32'd3);
    repeat (len - 2) begin
      chk("frame_mid_latch", 32'(bus.colour_latch), 32'd0);
      cyc(1);
      #1;
    end
    bus.frame_eop = 1'b1;
    #1;
    chk("frame_eop_latch", 32'(bus.colour_latch), 32'(exp_latch));
    cyc(1);
    bus.frame_eop = 1'b0;
  endtask

  initial begin
    bus.direction   = 4'd4;
    bus.capture_req = 1'b0;
    bus.frame_sop   = 1'b0;
    bus.frame_eop   = 1'b0;
    bus.sender_idle = 1'b1;

    #1;
    chk_core("rst", 0, 1'b1, 1'b0);
    chk("rst_terr",  32'(bus.timeout_err), 32'd0);
    chk("rst_latch", 32'(bus.colour_latch), 32'd0);
    chk("rst_start", 32'(bus.sender_start), 32'd0);
    cyc(3);
    rst_n = 1'b1;

    // 1: direction parked on the idle code from power-up must not trigger
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      #1;
      chk_core("t1_idle", 0, 1'b1, 1'b0);
    end

    // 2: direction entry 3->4 triggers, two frames, send, cooldown
    bus.direction = 4'd3;
    cyc(1);
    bus.direction = 4'd4;
    #1;
    chk_core("t2_trig", 0, 1'b1, 1'b0);
    cyc(1);
    #1;
    chk_core("t2_pend", 0, 1'b1, 1'b0);
    cyc(1);
    #1;
    chk_core("t2_settle", 1, 1'b0, 1'b1);
    cyc(3);
    #1;
    chk("t2_settle_end", 32'(bus.state_out), 32'd1);
    cyc(1);
    #1;
    chk("t2_wait_sop", 32'(bus.state_out), 32'd2);
    do_frame(20, 1'b0);
    #1;
    chk("t2_frame1_done", 32'(bus.state_out), 32'd2);
    do_frame(20, 1'b1);
    #1;
    chk("t2_send", 32'(bus.state_out), 32'd4);
    chk("t2_sstart", 32'(bus.sender_start), 32'd1);
    chk("t2_nlatch", 32'(n_latch), 32'd1);
    cyc(1);
    #1;
    chk("t2_sstart_off", 32'(bus.sender_start), 32'd0);
    chk("t2_nstart", 32'(n_start), 32'd1);
    bus.sender_idle = 1'b0;
    cyc(3);
    #1;
    chk("t2_send_busy", 32'(bus.state_out), 32'd4);
    bus.sender_idle = 1'b1;
    cyc(1);
    #1;
    chk_core("t2_cool", 5, 1'b1, 1'b1);
    cyc(2);
    #1;
    chk("t2_cool_end", 32'(bus.state_out), 32'd5);
    cyc(1);
    #1;
    chk_core("t2_listen", 0, 1'b1, 1'b0);

    // 3: stray eop, restarted frame, then one good frame -> latch on 2nd good eop
    bus.capture_req = 1'b1;
    cyc(1);
    bus.capture_req = 1'b0;
    #1;
    chk("t3_pend", 32'(bus.state_out), 32'd0);
    cyc(1);
    #1;
    chk_core("t3_settle", 1, 1'b0, 1'b1);
    cyc(4);
    #1;
    chk("t3_wait_sop", 32'(bus.state_out), 32'd2);
    bus.frame_eop = 1'b1;
    #1;
    chk("t3_stray_eop_latch", 32'(bus.colour_latch), 32'd0);
    cyc(1);
    bus.frame_eop = 1'b0;
    #1;
    chk("t3_stray_eop_state", 32'(bus.state_out), 32'd2);
    bus.frame_sop = 1'b1;
    cyc(1);
    bus.frame_sop = 1'b0;
    #1;
    chk("t3_in_frame", 32'(bus.state_out), 32'd3);
    cyc(5);
    bus.frame_sop = 1'b1;
    cyc(1);
    bus.frame_sop = 1'b0;
    #1;
    chk("t3_restart", 32'(bus.state_out), 32'd3);
    cyc(5);
    bus.frame_eop = 1'b1;
    #1;
    chk("t3_first_eop_latch", 32'(bus.colour_latch), 32'd0);
    cyc(1);
    bus.frame_eop = 1'b0;
    #1;
    chk("t3_count1", 32'(bus.state_out), 32'd2);
    do_frame(20, 1'b1);
    #1;
    chk("t3_send", 32'(bus.state_out), 32'd4);
    chk("t3_nlatch", 32'(n_latch), 32'd2);

    // 4: two capture requests during SEND collapse into one follow-up capture
    bus.capture_req = 1'b1;
    cyc(1);
    bus.capture_req = 1'b0;
    cyc(1);
    bus.capture_req = 1'b1;
    cyc(1);
    bus.capture_req = 1'b0;
    #1;
    chk("t4_still_send", 32'(bus.state_out), 32'd4);
    bus.sender_idle = 1'b0;
    cyc(1);
    bus.sender_idle = 1'b1;
    #1;
    chk("t4_acked", 32'(bus.state_out), 32'd4);
    cyc(1);
    #1;
    chk_core("t4_cool", 5, 1'b1, 1'b1);
    cyc(2);
    #1;
    chk("t4_cool_end", 32'(bus.state_out), 32'd5);
    cyc(1);
    #1;
    chk_core("t4_listen", 0, 1'b1, 1'b0);
    chk("t4_nstart", 32'(n_start), 32'd2);
    cyc(1);
    #1;
    chk_core("t4_retrigger", 1, 1'b0, 1'b1);

    // 5: no sop for the whole timeout window -> sticky error, no pulses
    cyc(4);
    #1;
    chk("t5_wait_sop", 32'(bus.state_out), 32'd2);
    cyc(99);
    #1;
    chk("t5_last_wait", 32'(bus.state_out), 32'd2);
    chk("t5_terr_pre", 32'(bus.timeout_err), 32'd0);
    cyc(1);
    #1;
    chk_core("t5_abort", 5, 1'b1, 1'b1);
    chk("t5_terr", 32'(bus.timeout_err), 32'd1);
    cyc(3);
    #1;
    chk_core("t5_listen", 0, 1'b1, 1'b0);
    cyc(10);
    #1;
    chk_core("t5_no_extra", 0, 1'b1, 1'b0);
    chk("t5_terr_sticky", 32'(bus.timeout_err), 32'd1);
    chk("t5_nlatch", 32'(n_latch), 32'd2);
    chk("t5_nstart", 32'(n_start), 32'd2);

    // 6: reset in the middle of SEND with a request pending
    bus.capture_req = 1'b1;
    cyc(1);
    bus.capture_req = 1'b0;
    cyc(5);
    #1;
    chk("t6_wait_sop", 32'(bus.state_out), 32'd2);
    do_frame(20, 1'b0);
    do_frame(20, 1'b1);
    bus.capture_req = 1'b1;
    cyc(1);
    bus.capture_req = 1'b0;
    #1;
    chk("t6_send", 32'(bus.state_out), 32'd4);
    chk("t6_terr_pre", 32'(bus.timeout_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_core("t6_rst", 0, 1'b1, 1'b0);
    chk("t6_rst_terr",  32'(bus.timeout_err), 32'd0);
    chk("t6_rst_start", 32'(bus.sender_start), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    #1;
    chk_core("t6_after", 0, 1'b1, 1'b0);
    cyc(5);
    #1;
    chk_core("t6_discarded", 0, 1'b1, 1'b0);
    chk("t6_nlatch", 32'(n_latch), 32'd3);
    chk("t6_nstart", 32'(n_start), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
